video_overlay_mixer: RTL and testbench

Parametrised successor to the fixed RGB111→RGB666 output path. Combines Pi DPI video (CB-bit per channel) with the AIV graphics overlay (OB-bit per channel) into one SCART RGB stream. Supports four selectable mix modes. Mode changes take effect only at field boundaries, with an optional multi-field crossfade. Sits between active_frame_tracker/sync_signals and the SCART pins on sysClk, qualified by pixelClockX1_en.

---
 rtl/vp415_video_pkg.sv | 32 +++
 rtl/channel_fader.sv | 42 ++++
 rtl/video_overlay_mixer.sv | 200 ++++++++++++++++++++
 tb/tb_video_overlay_mixer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vp415_video_pkg.sv
// Shared types and helpers for the SCART video output path: mix modes,
// control FSM states and overlay bit-depth expansion.
package vp415_video_pkg;

    typedef enum logic [1:0] {
        MODE_PI_ONLY  = 2'd0,
        MODE_OVL_ONLY = 2'd1,
        MODE_KEYED    = 2'd2,
        MODE_BLEND    = 2'd3
    } mode_t;

    typedef enum logic [0:0] {
        STEADY = 1'b0,
        FADING = 1'b1
    } ctrl_state_t;

    localparam int MAX_BITS = 16;

    // MSB-first replication of an ob-bit value across cb bits (1 -> all ones, 2'b10 -> 101010)
    function automatic logic [MAX_BITS-1:0] expand_bits(input logic [MAX_BITS-1:0] value,
                                                        input int ob, input int cb);
        logic [MAX_BITS-1:0] res;
        int idx;
        res = '0;
        for (int j = 0; j < MAX_BITS; j++) begin
            idx    = (j < cb) ? (ob - 1 - ((cb - 1 - j) % ob)) : 0;
            res[j] = (j < cb) ? value[idx] : 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/channel_fader.sv
// One colour channel of the crossfade: weights the old-mode and new-mode
// pixels by alpha out of 2^FADE_LOG2 and registers the blanked result.
module channel_fader
#(
    parameter int CB        = 6,
    parameter int FADE_LOG2 = 2
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pixel_en,
    input  logic                 de,
    input  logic [CB-1:0]        old_px,
    input  logic [CB-1:0]        new_px,
    input  logic [FADE_LOG2:0]   alpha,
    output logic [CB-1:0]        px
);

    localparam int W = CB + FADE_LOG2 + 1;
    localparam logic [W-1:0] FULL = W'(1 << FADE_LOG2);

    logic [W-1:0]  weightedSum_s;
    logic [CB-1:0] mixed_s;

    // Weighted sum, truncated back to channel width
    always_comb begin
        weightedSum_s = W'(old_px) * (FULL - W'(alpha)) + W'(new_px) * W'(alpha);
        mixed_s       = CB'(weightedSum_s >> FADE_LOG2);
    end

    // Output register, forced to black outside the active picture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            px <= '0;
        end else if (pixel_en) begin
            px <= de ? mixed_s : '0;
        end else begin
            px <= px;
        end
    end

endmodule

// File: rtl/video_overlay_mixer.sv
// Mixes Pi DPI video with the AIV overlay into one SCART RGB stream; mode
// switches land on field boundaries with an optional multi-field crossfade.
module video_overlay_mixer
    import vp415_video_pkg::*;
#(
    parameter int CB           = 6,
    parameter int OB           = 1,
    parameter int FADE_LOG2    = 2,
    parameter int DEFAULT_MODE = 0
)
(
    input  logic          clk,
    input  logic          reset,
    input  logic          pixel_en,
    input  logic          vsync,
    input  logic          display_enable,
    input  logic [CB-1:0] pi_red,
    input  logic [CB-1:0] pi_green,
    input  logic [CB-1:0] pi_blue,
    input  logic [OB-1:0] ovl_red,
    input  logic [OB-1:0] ovl_green,
    input  logic [OB-1:0] ovl_blue,
    input  logic [1:0]    mode_req,
    input  logic          mode_req_valid,
    output logic [CB-1:0] red_out,
    output logic [CB-1:0] green_out,
    output logic [CB-1:0] blue_out,
    output logic          de_out,
    output logic [1:0]    mode_active,
    output logic          fading
);

    localparam int AW = FADE_LOG2 + 1;
    localparam mode_t RESET_MODE = mode_t'(2'(DEFAULT_MODE));
    localparam logic [AW-1:0] ALPHA_LAST = AW'((1 << FADE_LOG2) - 1);

    ctrl_state_t   state_r, nextState_s;
    mode_t         modeActive_r, nextActive_s, oldMode_r, nextOld_s, pendMode_r, nextPendMode_s;
    logic          pendValid_r, nextPendValid_s, pendClear_s;
    logic [AW-1:0] alpha_r, nextAlpha_s;
    logic          vsyncPrev_r, vsyncEdge_s;

    logic [CB-1:0] piR1_r, piG1_r, piB1_r;
    logic [OB-1:0] ovlR1_r, ovlG1_r, ovlB1_r;
    logic          de1_r;
    logic [CB-1:0] ovlExpR_s, ovlExpG_s, ovlExpB_s;
    logic          key_s;

    logic [CB-1:0] oldR2_r, oldG2_r, oldB2_r, newR2_r, newG2_r, newB2_r;
    logic [AW-1:0] alpha2_r;
    logic          de2_r;

    function automatic logic [CB-1:0] mixPixel(input mode_t mode, input logic [CB-1:0] pi,
                                               input logic [CB-1:0] ovl, input logic key);
        logic [CB:0]   sum;
        logic [CB-1:0] res;
        sum = {1'b0, pi} + {1'b0, ovl};
        case (mode)
            MODE_PI_ONLY:  res = pi;
            MODE_OVL_ONLY: res = ovl;
            MODE_KEYED:    res = key ? ovl : pi;
            MODE_BLEND:    res = CB'(sum >> 1);
            default:       res = pi;
        endcase
        return res;
    endfunction

    assign vsyncEdge_s = vsync & ~vsyncPrev_r;
    assign mode_active = modeActive_r;
    assign fading      = (state_r == FADING);

    // Field-boundary control: pending request capture, mode switch and fade stepping
    always_comb begin
        nextState_s     = state_r;
        nextActive_s    = modeActive_r;
        nextOld_s       = oldMode_r;
        nextAlpha_s     = alpha_r;
        pendClear_s     = 1'b0;
        case (state_r)
            STEADY: begin
                if (vsyncEdge_s && pendValid_r) begin
                    pendClear_s = 1'b1;
                    if (pendMode_r != modeActive_r) begin
                        nextActive_s = pendMode_r;
                        if (FADE_LOG2 > 0) begin
                            nextOld_s   = modeActive_r;
                            nextAlpha_s = AW'(1);
                            nextState_s = FADING;
                        end else begin
                            nextOld_s   = pendMode_r;
                        end
                    end else begin
                        nextActive_s = modeActive_r;
                    end
                end else begin
                    pendClear_s = 1'b0;
                end
            end
            FADING: begin
                if (vsyncEdge_s && (alpha_r == ALPHA_LAST)) begin
                    nextOld_s   = modeActive_r;
                    nextAlpha_s = '0;
                    nextState_s = STEADY;
                end else if (vsyncEdge_s) begin
                    nextAlpha_s = alpha_r + AW'(1);
                end else begin
                    nextAlpha_s = alpha_r;
                end
            end
            default: begin
                nextState_s = STEADY;
                nextAlpha_s = '0;
                nextOld_s   = modeActive_r;
            end
        endcase
        // A request coinciding with an edge is captured after that edge's decision
        if (mode_req_valid) begin
            nextPendValid_s = 1'b1;
            nextPendMode_s  = mode_t'(mode_req);
        end else if (pendClear_s) begin
            nextPendValid_s = 1'b0;
            nextPendMode_s  = pendMode_r;
        end else begin
            nextPendValid_s = pendValid_r;
            nextPendMode_s  = pendMode_r;
        end
    end

    // Control state registers; vsync edge detection runs every clk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= STEADY;
            modeActive_r <= RESET_MODE;
            oldMode_r    <= RESET_MODE;
            pendMode_r   <= RESET_MODE;
            pendValid_r  <= 1'b0;
            alpha_r      <= '0;
            vsyncPrev_r  <= 1'b0;
        end else begin
            state_r      <= nextState_s;
            modeActive_r <= nextActive_s;
            oldMode_r    <= nextOld_s;
            pendMode_r   <= nextPendMode_s;
            pendValid_r  <= nextPendValid_s;
            alpha_r      <= nextAlpha_s;
            vsyncPrev_r  <= vsync;
        end
    end

    // Overlay expansion and colour key for the stage-1 pixel
    always_comb begin
        ovlExpR_s = CB'(expand_bits(MAX_BITS'(ovlR1_r), OB, CB));
        ovlExpG_s = CB'(expand_bits(MAX_BITS'(ovlG1_r), OB, CB));
        ovlExpB_s = CB'(expand_bits(MAX_BITS'(ovlB1_r), OB, CB));
        key_s     = (|ovlR1_r) | (|ovlG1_r) | (|ovlB1_r);
    end

    // Stages 1 and 2: input capture, then per-mode pixels with alpha carried alongside
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {piR1_r, piG1_r, piB1_r, ovlR1_r, ovlG1_r, ovlB1_r, de1_r} <= '0;
            {oldR2_r, oldG2_r, oldB2_r, newR2_r, newG2_r, newB2_r}     <= '0;
            alpha2_r <= '0;
            de2_r    <= 1'b0;
            de_out   <= 1'b0;
        end else if (pixel_en) begin
            piR1_r   <= pi_red;
            piG1_r   <= pi_green;
            piB1_r   <= pi_blue;
            ovlR1_r  <= ovl_red;
            ovlG1_r  <= ovl_green;
            ovlB1_r  <= ovl_blue;
            de1_r    <= display_enable;
            oldR2_r  <= mixPixel(oldMode_r, piR1_r, ovlExpR_s, key_s);
            oldG2_r  <= mixPixel(oldMode_r, piG1_r, ovlExpG_s, key_s);
            oldB2_r  <= mixPixel(oldMode_r, piB1_r, ovlExpB_s, key_s);
            newR2_r  <= mixPixel(modeActive_r, piR1_r, ovlExpR_s, key_s);
            newG2_r  <= mixPixel(modeActive_r, piG1_r, ovlExpG_s, key_s);
            newB2_r  <= mixPixel(modeActive_r, piB1_r, ovlExpB_s, key_s);
            alpha2_r <= alpha_r;
            de2_r    <= de1_r;
            de_out   <= de2_r;
        end else begin
            de_out   <= de_out;
        end
    end

    channel_fader #(.CB(CB), .FADE_LOG2(FADE_LOG2)) u_fadeRed (
        .clk(clk), .reset(reset), .pixel_en(pixel_en), .de(de2_r),
        .old_px(oldR2_r), .new_px(newR2_r), .alpha(alpha2_r), .px(red_out));

    channel_fader #(.CB(CB), .FADE_LOG2(FADE_LOG2)) u_fadeGreen (
        .clk(clk), .reset(reset), .pixel_en(pixel_en), .de(de2_r),
        .old_px(oldG2_r), .new_px(newG2_r), .alpha(alpha2_r), .px(green_out));

    channel_fader #(.CB(CB), .FADE_LOG2(FADE_LOG2)) u_fadeBlue (
        .clk(clk), .reset(reset), .pixel_en(pixel_en), .de(de2_r),
        .old_px(oldB2_r), .new_px(newB2_r), .alpha(alpha2_r), .px(blue_out));

endmodule

// File: tb/tb_video_overlay_mixer.sv
// Randomised field-based bench for video_overlay_mixer: two instances (4-field
// crossfade and instant switch) checked against a field-level reference model.
module tb_video_overlay_mixer;

    localparam int CB = 6;
    localparam int OB = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pixel_en = 1'b0, vsync = 1'b0, display_enable = 1'b0;
    logic [CB-1:0] pi_red = '0, pi_green = '0, pi_blue = '0;
    logic [OB-1:0] ovl_red = '0, ovl_green = '0, ovl_blue = '0;
    logic [1:0] mode_req = 2'd0;
    logic mode_req_valid = 1'b0;

    logic [CB-1:0] red0, green0, blue0, red1, green1, blue1;
    logic de0, de1, fad0, fad1;
    logic [1:0] act0, act1;

    always #5 clk = ~clk;

    video_overlay_mixer #(.CB(CB), .OB(OB), .FADE_LOG2(2), .DEFAULT_MODE(0)) u_fade (
        .clk(clk), .reset(reset), .pixel_en(pixel_en), .vsync(vsync),
        .display_enable(display_enable), .pi_red(pi_red), .pi_green(pi_green), .pi_blue(pi_blue),
        .ovl_red(ovl_red), .ovl_green(ovl_green), .ovl_blue(ovl_blue),
        .mode_req(mode_req), .mode_req_valid(mode_req_valid),
        .red_out(red0), .green_out(green0), .blue_out(blue0), .de_out(de0),
        .mode_active(act0), .fading(fad0));

    video_overlay_mixer #(.CB(CB), .OB(OB), .FADE_LOG2(0), .DEFAULT_MODE(0)) u_inst (
        .clk(clk), .reset(reset), .pixel_en(pixel_en), .vsync(vsync),
        .display_enable(display_enable), .pi_red(pi_red), .pi_green(pi_green), .pi_blue(pi_blue),
        .ovl_red(ovl_red), .ovl_green(ovl_green), .ovl_blue(ovl_blue),
        .mode_req(mode_req), .mode_req_valid(mode_req_valid),
        .red_out(red1), .green_out(green1), .blue_out(blue1), .de_out(de1),
        .mode_active(act1), .fading(fad1));

    int vectors = 0;
    int miscompares = 0;

    // Reference model state, index 0 = crossfading instance, 1 = instant instance
    int fadeLog[2];
    int mAct[2], mOld[2], mAlpha[2], mPendM[2];
    bit mFad[2], mPendV[2];
    bit prevVs;
    logic [18:0] q0[$];
    logic [18:0] q1[$];
    logic [CB-1:0] fPiR, fPiG, fPiB;
    logic [OB-1:0] fOvlR, fOvlG, fOvlB;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic int expand(input int v);
        return v * ((1 << CB) - 1) / ((1 << OB) - 1);
    endfunction

    function automatic int mix(input int mode, input int pi, input int ovl, input bit key);
        case (mode)
            0: return pi;
            1: return ovl;
            2: return key ? ovl : pi;
            default: return (pi + ovl) / 2;
        endcase
    endfunction

    function automatic logic [18:0] expected(input int d);
        int pis[3], ovs[3], res[3];
        bit key;
        int n;
        if (!display_enable) return 19'd0;
        pis[0] = int'(pi_red); pis[1] = int'(pi_green); pis[2] = int'(pi_blue);
        ovs[0] = expand(int'(ovl_red)); ovs[1] = expand(int'(ovl_green)); ovs[2] = expand(int'(ovl_blue));
        key = (ovl_red != 0) || (ovl_green != 0) || (ovl_blue != 0);
        n = 1 << fadeLog[d];
        for (int c = 0; c < 3; c++)
            res[c] = (mix(mOld[d], pis[c], ovs[c], key) * (n - mAlpha[d])
                      + mix(mAct[d], pis[c], ovs[c], key) * mAlpha[d]) / n;
        return {1'b1, 6'(res[0]), 6'(res[1]), 6'(res[2])};
    endfunction

    task automatic model_reset();
        fadeLog[0] = 2; fadeLog[1] = 0;
        for (int d = 0; d < 2; d++) begin
            mAct[d] = 0; mOld[d] = 0; mAlpha[d] = 0; mPendM[d] = 0; mFad[d] = 0; mPendV[d] = 0;
        end
        prevVs = 1'b0;
        q0.delete(); q1.delete();
        repeat (2) begin q0.push_back(19'd0); q1.push_back(19'd0); end
    endtask

    // Advance the model by one clk using the inputs the DUT just sampled, then compare
    task automatic model_clock();
        bit edgeV, consumed;
        logic [18:0] e;
        edgeV = vsync && !prevVs;
        prevVs = vsync;
        for (int d = 0; d < 2; d++) begin
            consumed = 1'b0;
            if (edgeV) begin
                if (mFad[d]) begin
                    mAlpha[d]++;
                    if (mAlpha[d] == (1 << fadeLog[d])) begin
                        mFad[d] = 1'b0; mAlpha[d] = 0; mOld[d] = mAct[d];
                    end
                end else if (mPendV[d]) begin
                    consumed = 1'b1;
                    if (mPendM[d] != mAct[d]) begin
                        mOld[d] = (fadeLog[d] > 0) ? mAct[d] : mPendM[d];
                        mAct[d] = mPendM[d];
                        if (fadeLog[d] > 0) begin mAlpha[d] = 1; mFad[d] = 1'b1; end
                    end
                end
            end
            if (mode_req_valid) begin mPendV[d] = 1'b1; mPendM[d] = int'(mode_req); end
            else if (consumed) mPendV[d] = 1'b0;
        end
        check_value("mode_active0", 32'(act0), mAct[0]);
        check_value("fading0", 32'(fad0), 32'(mFad[0]));
        check_value("mode_active1", 32'(act1), mAct[1]);
        check_value("fading1", 32'(fad1), 32'(mFad[1]));
        if (pixel_en) begin
            q0.push_back(expected(0));
            q1.push_back(expected(1));
            e = q0.pop_front();
            check_value("pixel0", 32'({de0, red0, green0, blue0}), 32'(e));
            e = q1.pop_front();
            check_value("pixel1", 32'({de1, red1, green1, blue1}), 32'(e));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_clock();
    endtask

    task automatic strobe(input bit de, input bit rndPix, input int idle);
        display_enable = de;
        if (rndPix) begin
            pi_red = 6'($urandom_range(0, 63)); pi_green = 6'($urandom_range(0, 63));
            pi_blue = 6'($urandom_range(0, 63));
            ovl_red = 1'($urandom_range(0, 1)); ovl_green = 1'($urandom_range(0, 1));
            ovl_blue = 1'($urandom_range(0, 1));
        end else begin
            pi_red = fPiR; pi_green = fPiG; pi_blue = fPiB;
            ovl_red = fOvlR; ovl_green = fOvlG; ovl_blue = fOvlB;
        end
        pixel_en = 1'b1;
        cycle();
        pixel_en = 1'b0;
        repeat (idle) cycle();
    endtask

    task automatic request(input int m);
        mode_req = 2'(m);
        mode_req_valid = 1'b1;
        cycle();
        mode_req_valid = 1'b0;
    endtask

    // Blanking, vsync pulse (optionally with a coincident request), blanking, active picture
    task automatic field(input int nPix, input bit rndPix, input int midReq1, input int midReq2,
                         input int edgeReq, input bit rndReq);
        repeat (4) strobe(1'b0, rndPix, $urandom_range(0, 2));
        vsync = 1'b1;
        if (edgeReq >= 0) begin mode_req = 2'(edgeReq); mode_req_valid = 1'b1; end
        cycle();
        mode_req_valid = 1'b0;
        cycle();
        vsync = 1'b0;
        cycle();
        repeat (4) strobe(1'b0, rndPix, $urandom_range(0, 2));
        for (int i = 0; i < nPix; i++) begin
            strobe(1'b1, rndPix, $urandom_range(0, 2));
            if (i == 3 && midReq1 >= 0) request(midReq1);
            if (i == 6 && midReq2 >= 0) request(midReq2);
            if (rndReq && $urandom_range(0, 9) == 0) request($urandom_range(0, 3));
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            pixel_en = 1'($urandom_range(0, 1)); display_enable = 1'($urandom_range(0, 1));
            vsync = 1'($urandom_range(0, 1)); mode_req_valid = 1'($urandom_range(0, 1));
            mode_req = 2'($urandom_range(0, 3)); pi_red = 6'($urandom_range(0, 63));
            ovl_blue = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_value("rst_rgb0", 32'({red0, green0, blue0}), 32'd0);
            check_value("rst_de0", 32'(de0), 32'd0);
            check_value("rst_mode0", 32'(act0), 32'd0);
            check_value("rst_fade0", 32'(fad0), 32'd0);
            check_value("rst_rgb1", 32'({red1, green1, blue1}), 32'd0);
        end
        vsync = 1'b0; mode_req_valid = 1'b0;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            pixel_en = 1'($urandom_range(0, 1)); display_enable = 1'($urandom_range(0, 1));
            cycle();
            check_value("post_rst_rgb0", 32'({red0, green0, blue0}), 32'd0);
            check_value("post_rst_de0", 32'(de0), 32'd0);
        end
        pixel_en = 1'b0;

        // PI_ONLY latency and blanking
        {fPiR, fPiG, fPiB, fOvlR, fOvlG, fOvlB} = '0;
        repeat (3) strobe(1'b0, 1'b0, 0);
        fPiR = 6'h2A; strobe(1'b1, 1'b0, 0);
        check_value("lat_1", 32'(red0), 32'd0);
        fPiR = 6'h11; strobe(1'b1, 1'b0, 0);
        check_value("lat_2", 32'(red0), 32'd0);
        fPiR = 6'h22; strobe(1'b1, 1'b0, 0);
        check_value("lat_3", 32'(red0), 32'h2A);
        check_value("lat_3_de", 32'(de0), 32'd1);
        cycle();
        check_value("hold", 32'(red0), 32'h2A);
        repeat (3) strobe(1'b0, 1'b0, 0);
        check_value("de_off_red", 32'(red0), 32'd0);
        check_value("de_off_de", 32'(de0), 32'd0);

        // Requests held to the field edge; coincident request deferred
        field(16, 1'b1, 1, 3, -1, 1'b0);
        check_value("inst_hold", 32'(act1), 32'd0);
        field(16, 1'b1, -1, -1, 2, 1'b0);
        check_value("inst_edge", 32'(act1), 32'd3);
        field(16, 1'b1, -1, -1, -1, 1'b0);
        check_value("inst_deferred", 32'(act1), 32'd2);
        // KEYED on the instant instance
        fPiR = 6'h15; fPiG = 6'h15; fPiB = 6'h15; fOvlR = 1'b0; fOvlG = 1'b0; fOvlB = 1'b1;
        field(16, 1'b0, -1, -1, -1, 1'b0);
        check_value("key_blue", 32'(blue1), 32'h3F);
        check_value("key_red", 32'(red1), 32'd0);
        check_value("key_green", 32'(green1), 32'd0);
        fOvlB = 1'b0;
        field(16, 1'b0, -1, -1, -1, 1'b0);
        check_value("key_none", 32'({red1, green1, blue1}), 32'({6'h15, 6'h15, 6'h15}));

        // Four-field crossfade PI_ONLY -> OVL_ONLY, then a held request
        pulse_reset();
        fPiR = 6'h00; fPiG = 6'h00; fPiB = 6'h00; fOvlR = 1'b1; fOvlG = 1'b1; fOvlB = 1'b1;
        field(16, 1'b0, 1, -1, -1, 1'b0);
        check_value("fade_pre", 32'(red0), 32'd0);
        field(16, 1'b0, -1, -1, -1, 1'b0);
        check_value("fade_f1", 32'(red0), 32'd15);
        check_value("fade_f1_flag", 32'(fad0), 32'd1);
        field(16, 1'b0, 0, -1, -1, 1'b0);
        check_value("fade_f2", 32'(red0), 32'd31);
        field(16, 1'b0, -1, -1, -1, 1'b0);
        check_value("fade_f3", 32'(red0), 32'd47);
        check_value("fade_f3_flag", 32'(fad0), 32'd1);
        field(16, 1'b0, -1, -1, -1, 1'b0);
        check_value("fade_f4", 32'(red0), 32'd63);
        check_value("fade_f4_flag", 32'(fad0), 32'd0);
        check_value("fade_f4_mode", 32'(act0), 32'd1);
        field(16, 1'b0, -1, -1, -1, 1'b0);
        check_value("held_mode", 32'(act0), 32'd0);
        check_value("held_red", 32'(red0), 32'd47);
        field(8, 1'b0, -1, -1, -1, 1'b0);
        check_value("second_field_red", 32'(red0), 32'd31);

        // Reset in the middle of the second fade field
        #2;
        reset = 1'b1;
        #1;
        check_value("midfade_mode", 32'(act0), 32'd0);
        check_value("midfade_fading", 32'(fad0), 32'd0);
        check_value("midfade_rgb", 32'({red0, green0, blue0}), 32'd0);
        check_value("midfade_de", 32'(de0), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Random fields with random mode traffic
        for (int f = 0; f < 30; f++)
            field($urandom_range(6, 20), 1'b1, -1, -1,
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
